// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a time-multiplexed, active-low 7-segment bus,
// decodes each strobed digit to BCD, assembles a frame, and commits it as BCD
// plus a binary value with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   seg_n         segment lines (active-low), bit7 = dp, bits6:0 = g..a
//   dig_en_n      digit strobes (active-low, one-hot when valid), digit 0 = ones
//   bcd_out       last committed BCD digits, digit i at [4i+3:4i]
//   dp_out        last committed decimal points (active-high)
//   value_out     binary value of bcd_out (0x3FF if any digit undecodable)
//   value_valid   one-cycle pulse on each commit
//   frame_err     committed frame contained an undecodable pattern
//   stale         no frame committed within TIMEOUT_CYCLES
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [9:0]              value_out,
  output logic                    value_valid,
  output logic                    frame_err,
  output logic                    stale
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned NL_W  = IDX_W + 1;
  localparam int unsigned SET_W = 8;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  // Returns {bad, code}; blank decodes to 0 without error.
  function automatic logic [4:0] decode7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h7F:   r = 5'h00;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  // Two-flop synchronizers; idle level is all-ones (nothing driven).
  logic [7:0]            seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0] en_s1_q, en_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      en_s1_q  <= '1;
      en_s2_q  <= '1;
    end else begin
      seg_s1_q <= seg_n;
      seg_s2_q <= seg_s1_q;
      en_s1_q  <= dig_en_n;
      en_s2_q  <= en_s1_q;
    end
  end

  // Active strobe: exactly one low enable bit.
  logic             act_c;
  logic [IDX_W-1:0] act_idx_c;
  logic [NL_W-1:0]  nlow_c;

  always_comb begin
    nlow_c    = '0;
    act_idx_c = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!en_s2_q[i]) begin
        nlow_c    = nlow_c + NL_W'(1);
        act_idx_c = IDX_W'(i);
      end
    end
    act_c = (nlow_c == NL_W'(1));
  end

  // Scan FSM state and latched digit context.
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       pat_q, pat_d;
  logic [SET_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pat_q   <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (act_c) begin
          idx_d   = act_idx_c;
          pat_d   = seg_s2_q;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!act_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if ((act_idx_c != idx_q) || (seg_s2_q != pat_q)) begin
          // Any bounce restarts the stability window on the new pattern.
          idx_d = act_idx_c;
          pat_d = seg_s2_q;
          cnt_d = '0;
        end else if (cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!act_c || (act_idx_c != idx_q)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Frame assembly, timeout and commit.
  logic [BCD_W-1:0]      slots_q, slots_d;
  logic [NUM_DIGITS-1:0] dps_q, dps_d;
  logic [NUM_DIGITS-1:0] captured_q, captured_d;
  logic                  err_q, err_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  stale_q, stale_d;
  logic [BCD_W-1:0]      bcd_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [9:0]            value_q, value_c;
  logic                  valid_q;
  logic                  ferr_q;

  logic       cap_c;
  logic       commit_c;
  logic       to_hit_c;
  logic       err_set_c;
  logic [4:0] dec_c;
  logic [11:0] pad_c;

  always_comb begin
    cap_c      = (state_q == S_CAPTURE);
    dec_c      = decode7(pat_q[6:0]);
    slots_d    = slots_q;
    dps_d      = dps_q;
    captured_d = captured_q;
    if (cap_c) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          slots_d[4*i +: 4] = dec_c[3:0];
          dps_d[i]          = ~pat_q[7];
          captured_d[i]     = 1'b1;
        end
      end
    end
    err_set_c = err_q | (cap_c & dec_c[4]);
    commit_c  = cap_c && (&captured_d);
    to_hit_c  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    err_d    = err_set_c;
    stale_d  = stale_q;
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (cap_c) begin
      // A capture beats a coincident terminal count.
      to_cnt_d = '0;
    end else if (to_hit_c) begin
      to_cnt_d   = '0;
      captured_d = '0;
      err_d      = 1'b0;
      stale_d    = 1'b1;
    end
    if (commit_c) begin
      captured_d = '0;
      err_d      = 1'b0;
      stale_d    = 1'b0;
    end

    // Missing upper digits read as zero.
    pad_c = 12'(slots_d);
    if ((pad_c[3:0] == 4'hF) || (pad_c[7:4] == 4'hF) || (pad_c[11:8] == 4'hF)) begin
      value_c = 10'h3FF;
    end else begin
      value_c = 10'(pad_c[3:0]) + (10'(pad_c[7:4]) * 10'd10) + (10'(pad_c[11:8]) * 10'd100);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots_q    <= '0;
      dps_q      <= '0;
      captured_q <= '0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      stale_q    <= 1'b1;
      bcd_q      <= '0;
      dp_q       <= '0;
      value_q    <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      dps_q      <= dps_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      stale_q    <= stale_d;
      valid_q    <= commit_c;
      if (commit_c) begin
        bcd_q   <= slots_d;
        dp_q    <= dps_d;
        value_q <= value_c;
        ferr_q  <= err_set_c;
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign dp_out      = dp_q;
  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign frame_err   = ferr_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed strobe sequences push expected frames
// into a scoreboard; a negedge monitor pops and compares on each value_valid.
module tb_seg7_scan_decoder;

  localparam int unsigned NUM_DIGITS = 2;
  localparam int unsigned SETTLE     = 8;
  localparam int unsigned TIMEOUT    = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_n;
  logic [1:0] dig_en_n;
  logic [7:0] bcd_out;
  logic [1:0] dp_out;
  logic [9:0] value_out;
  logic       value_valid;
  logic       frame_err;
  logic       stale;

  seg7_scan_decoder #(
    .NUM_DIGITS    (NUM_DIGITS),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .dig_en_n   (dig_en_n),
    .bcd_out    (bcd_out),
    .dp_out     (dp_out),
    .value_out  (value_out),
    .value_valid(value_valid),
    .frame_err  (frame_err),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bcd;
    logic [1:0] dp;
    logic [9:0] value;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && value_valid) begin
      valid_cnt++;
      check("valid_width", 32'(valid_prev), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
        check("dp_out", 32'(dp_out), 32'(e.dp));
        check("value_out", 32'(value_out), 32'(e.value));
        check("frame_err", 32'(frame_err), 32'(e.err));
        check("stale_at_commit", 32'(stale), 32'd0);
      end
    end
    valid_prev = value_valid;
  end

  task automatic push_exp(input logic [7:0] bcd, input logic [1:0] dp,
                          input logic [9:0] value, input logic err);
    exp_t e;
    e.bcd   = bcd;
    e.dp    = dp;
    e.value = value;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] en, input logic [7:0] seg);
    @(posedge clk);
    #1;
    dig_en_n = en;
    seg_n    = seg;
  endtask

  // Strobe one digit for hold cycles, then release with a short gap.
  task automatic strobe(input int d, input logic [7:0] seg, input int hold);
    drive((d == 0) ? 2'b10 : 2'b01, seg);
    repeat (hold) @(posedge clk);
    drive(2'b11, 8'hFF);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_stale"}, 32'(stale), 32'd1);
    check({tag, "_valid"}, 32'(value_valid), 32'd0);
    check({tag, "_bcd"}, 32'(bcd_out), 32'd0);
    check({tag, "_value"}, 32'(value_out), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_dp"}, 32'(dp_out), 32'd0);
  endtask

  initial begin
    int v0;
    rst_n    = 1'b0;
    dig_en_n = 2'b11;
    seg_n    = 8'hFF;
    repeat (2) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ones=5, tens=3 -> 35; stale stays up until the commit.
    strobe(0, 8'h92, 20);
    @(negedge clk);
    check("stale_partial", 32'(stale), 32'd1);
    push_exp(8'h35, 2'b00, 10'd35, 1'b0);
    strobe(1, 8'hB0, 20);
    @(negedge clk);
    check("stale_after_commit", 32'(stale), 32'd0);

    // Bouncing 5<->9 never settles; only the final stable 9 is taken.
    for (int k = 0; k < 4; k++) begin
      drive(2'b10, (k % 2 == 0) ? 8'h92 : 8'h90);
      repeat (2) @(posedge clk);
    end
    drive(2'b10, 8'h90);
    repeat (20) @(posedge clk);
    drive(2'b11, 8'hFF);
    repeat (3) @(posedge clk);
    push_exp(8'h19, 2'b00, 10'd19, 1'b0);
    strobe(1, 8'hF9, 20);

    // Both strobes low is not an active digit: no capture, no commit.
    strobe(0, 8'h99, 20);
    v0 = valid_cnt;
    drive(2'b00, 8'hC0);
    repeat (50) @(posedge clk);
    drive(2'b11, 8'hFF);
    repeat (3) @(posedge clk);
    check("both_low_no_valid", 32'(valid_cnt - v0), 32'd0);
    push_exp(8'h64, 2'b00, 10'd64, 1'b0);
    strobe(1, 8'h82, 20);

    // Blank ones decodes to 0; then an undecodable ones digit.
    push_exp(8'h80, 2'b00, 10'd80, 1'b0);
    strobe(0, 8'hFF, 20);
    strobe(1, 8'h80, 20);
    push_exp(8'h8F, 2'b00, 10'h3FF, 1'b1);
    strobe(0, 8'hD5, 20);
    strobe(1, 8'h80, 20);

    // Lone ones digit times out and is dropped.
    strobe(0, 8'hC0, 20);
    v0 = valid_cnt;
    repeat (TIMEOUT + 30) @(posedge clk);
    @(negedge clk);
    check("stale_timeout", 32'(stale), 32'd1);
    check("timeout_no_valid", 32'(valid_cnt - v0), 32'd0);
    strobe(1, 8'h24, 20);
    @(negedge clk);
    check("dropped_ones_no_commit", 32'(valid_cnt - v0), 32'd0);
    check("stale_still_set", 32'(stale), 32'd1);
    push_exp(8'h24, 2'b10, 10'd24, 1'b0);
    strobe(0, 8'h99, 20);

    // Reset after ones is captured discards the partial frame.
    drive(2'b10, 8'hF9);
    repeat (20) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    dig_en_n = 2'b11;
    seg_n    = 8'hFF;
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = valid_cnt;
    strobe(1, 8'hB0, 20);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_reset_no_commit", 32'(valid_cnt - v0), 32'd0);
    check("post_reset_value", 32'(value_out), 32'd0);
    check("post_reset_stale", 32'(stale), 32'd1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("total_commits", 32'(valid_cnt), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment display path: samples an external time-multiplexed, active-low 7-segment bus (segment lines plus digit strobes).
- Decodes each strobed digit back to BCD, assembles a full frame and converts it to binary.
- Delivers the result with a one-cycle valid pulse.
- Used to read front-panel readouts of external modules into register space.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (legal range 1..3); digit 0 = ones.
- SETTLE_CYCLES, 8, clock cycles an enable/segment pattern must be stable before it is sampled (legal range 1..255).
- TIMEOUT_CYCLES, 100000, cycles without a captured digit before the partial frame is dropped and stale asserts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seg_n  in  8  segment lines, active-low; bit7 = dp, bits6:0 = g..a
- dig_en_n  in  NUM_DIGITS  digit strobes, active-low, one-hot when valid
- bcd_out  out  4*NUM_DIGITS  last committed BCD digits; digit i at [4i+3:4i]
- dp_out  out  NUM_DIGITS  last committed decimal-point bits, active-high
- value_out  out  10  binary value of bcd_out
- value_valid  out  1  one-cycle pulse when a new frame is committed
- frame_err  out  1  committed frame contained an undecodable pattern
- stale  out  1  no frame committed within TIMEOUT_CYCLES

Behaviour:
- Reset (async, rst_n=0): all outputs 0, except stale=1. FSM goes to IDLE. Partial frame, captured mask and counters cleared. Reset mid-frame discards the frame.
- seg_n and dig_en_n pass through a 2-flop synchronizer. All following timing is relative to the synchronized signals.
- "Active" means exactly one dig_en_n bit is 0. Zero or more than one low bit means none.
- FSM:
  - IDLE: on an active enable, latch the index and pattern, clear the settle counter, go to SETTLE.
  - SETTLE: the counter increments while the index and seg_n are unchanged. Any change reloads the new pattern/index (or returns to IDLE if none is active) and clears the counter. Reaching SETTLE_CYCLES goes to CAPTURE.
  - CAPTURE (1 cycle): decode the pattern into frame slot[index], set captured[index], go to HOLD.
  - HOLD: wait until the enable is no longer active or the index changes, then go to IDLE. A re-strobe of an already captured digit overwrites its slot.
- Decode, bits6:0 active-low:
  - 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9.
  - 0x7F (blank) decodes to 0 with no error.
  - Any other pattern gives code 0xF and sets the frame error bit.
  - dp = ~seg_n[7].
- Commit:
  - Triggered the cycle after CAPTURE in which captured becomes all-ones.
  - Registers bcd_out, dp_out and frame_err.
  - value_out = d2*100 + d1*10 + d0, with missing digits = 0. Any digit coded 0xF forces value_out = 0x3FF.
  - value_valid pulses for exactly 1 cycle. Latency is 1 cycle after CAPTURE.
  - Clears captured, the frame error bit and stale, and restarts the timeout counter.
- Between commits, outputs hold their last values.
- Timeout:
  - The counter increments every cycle and clears on each CAPTURE.
  - At TIMEOUT_CYCLES it clears captured and the frame error bit, and sets stale=1.
  - stale stays 1 until the next commit.
  - A CAPTURE in the same cycle as terminal count wins: the counter clears and stale is not set.
- Arithmetic: value_out max 999 fits in 10 bits. Multipliers are constants with no truncation.

Test Plan:
- Two digits: strobe ones=0x12, then tens=0x30, each held 20 cycles -> value_valid one pulse; bcd_out=0x35, value_out=35, frame_err=0, stale 1->0.
- Pattern bounces (0x12<->0x10 every 3 cycles for 12 cycles, then 0x10 stable), SETTLE_CYCLES=8 -> only 9 captured; no capture of 5.
- dig_en_n=2'b00 (both low) with valid seg_n for 50 cycles -> no capture, no value_valid.
- Ones=0x7F blank, tens=0x00 -> bcd_out=0x80, value_out=80. Repeat with ones=0x55 -> frame_err=1, bcd_out[3:0]=0xF, value_out=0x3FF.
- Capture ones only, then idle for TIMEOUT_CYCLES (set 200) -> stale=1, no value_valid. Then a full frame 4,2 -> value_out=24, stale=0.
- Assert rst_n=0 after the ones digit is captured; release; strobe tens only -> no commit. All outputs 0, stale=1 during reset.
